// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port unified memory between the CPU instruction-fetch
// port (I) and the CPU data port (D). The memory holds an instruction window
// in its lower half and a data window in its upper half. Each port uses a
// req/ack handshake. Byte addresses are translated to word addresses, ties
// are broken round-robin, and out-of-window or misaligned accesses complete
// with err=1 and never touch the memory.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample requests, grant one, latch the translated access
// ISSUE  | single mem_en cycle (write commits here)
// WAIT   | read latency down-counter; capture mem_rdata on terminal count
// ACK    | one-cycle ack (and err) pulse to the granted port
//
// Ports
//   clk_in, reset                 clock, async active-high reset
//   i_req/i_addr                  fetch request (read only)
//   i_ack/i_rdata/i_err           fetch completion, held read data, error
//   d_req/d_we/d_addr/d_wdata     data request
//   d_ack/d_rdata/d_err           data completion, held read data, error
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           single-port memory interface
//   busy                          high whenever the FSM is not in IDLE
module unified_mem_arbiter #(
    parameter logic [31:0] IBASE = 32'h00400000,
    parameter logic [31:0] DBASE = 32'h10010000,
    parameter int          AW    = 11,
    parameter int          LAT   = 1
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam int          CW        = (LAT > 1) ? $clog2(LAT) : 1;
    // Each window is 2^(AW-1) words, i.e. 2^(AW+1) bytes.
    localparam logic [31:0] WIN_BYTES = 32'd1 << (AW + 1);

    // Port encoding: 0 = I, 1 = D.
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_port;
    logic            r_last_grant;
    logic            r_we;
    logic            r_err;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_i_rdata;
    logic [31:0]     r_d_rdata;
    logic [CW-1:0]   r_cnt;

    logic            w_gnt_valid;
    logic            w_gnt_port;
    logic [31:0]     w_addr;
    logic [31:0]     w_base;
    logic [31:0]     w_off;
    logic            w_err;
    logic            w_we;
    logic [AW-1:0]   w_maddr;
    logic            w_wait_done;

    // Grant: a lone request wins; on a tie the port not granted last wins.
    // last_grant resets to I, so the first tie after reset goes to D.
    assign w_gnt_valid = i_req | d_req;
    assign w_gnt_port  = (i_req && d_req) ? ~r_last_grant : d_req;
    assign w_addr      = w_gnt_port ? d_addr : i_addr;
    assign w_base      = w_gnt_port ? DBASE : IBASE;
    // Modular subtraction: an address below the base wraps to a huge offset
    // and is caught by the same window-size compare.
    assign w_off       = w_addr - w_base;
    assign w_err       = (w_addr[1:0] != 2'b00) || (w_off >= WIN_BYTES);
    assign w_we        = w_gnt_port & d_we;
    assign w_maddr     = {w_gnt_port, w_off[AW:2]};
    assign w_wait_done = (r_cnt == '0);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = w_err ? S_ACK : S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = r_we ? S_ACK : S_WAIT;
            S_WAIT: begin
                if (w_wait_done) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_port       <= 1'b0;
            r_last_grant <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_port       <= w_gnt_port;
                        r_last_grant <= w_gnt_port;
                        r_addr       <= w_maddr;
                        r_we         <= w_we;
                        r_wdata      <= d_wdata;
                        r_err        <= w_err;
                        r_cnt        <= CW'(LAT - 1);
                        // Errored accesses skip the memory; clear rdata now so
                        // it reads 0 during the ack cycle.
                        if (w_err) begin
                            if (w_gnt_port) begin
                                r_d_rdata <= '0;
                            end else begin
                                r_i_rdata <= '0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        if (r_port) begin
                            r_d_rdata <= mem_rdata;
                        end else begin
                            r_i_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);
    assign i_ack     = (r_state == S_ACK) & ~r_port;
    assign d_ack     = (r_state == S_ACK) & r_port;
    assign i_err     = i_ack & r_err;
    assign d_err     = d_ack & r_err;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
    localparam int          AW     = 11;
    localparam int          LAT    = 1;
    localparam logic [31:0] IBASE  = 32'h00400000;
    localparam logic [31:0] DBASE  = 32'h10010000;
    localparam int          WWORDS = 1 << (AW - 1);
    localparam logic [31:0] WBYTES = 32'(4 * WWORDS);

    logic          clk_in = 1'b0;
    logic          reset  = 1'b0;
    logic          i_req  = 1'b0;
    logic [31:0]   i_addr = '0;
    logic          i_ack;
    logic [31:0]   i_rdata;
    logic          i_err;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [31:0]   d_addr  = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;

    always #5 clk_in = ~clk_in;

    unified_mem_arbiter #(
        .IBASE(IBASE), .DBASE(DBASE), .AW(AW), .LAT(LAT)
    ) dut (
        .clk_in(clk_in), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory with LAT-cycle read latency after the mem_en cycle.
    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] rd_pipe [0:LAT-1];
    always @(posedge clk_in) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        rd_pipe[0] <= mem[mem_addr];
        end
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;
    req_t iq[$];
    req_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_en   = 1'b0;

    // Reference model: one outstanding transaction described by its grant
    // cycle, ack cycle and payload; memory contents tracked in ref_mem.
    bit            act    = 1'b0;
    bit            t_port = 1'b0;
    bit            t_err  = 1'b0;
    bit            t_we   = 1'b0;
    int            t_start = 0;
    int            t_ack   = 0;
    logic [AW-1:0] t_maddr = '0;
    logic [31:0]   t_wdata = '0;
    logic [31:0]   t_data  = '0;
    bit            m_last  = 1'b0;
    logic [31:0]   e_irdata = '0;
    logic [31:0]   e_drdata = '0;
    logic [31:0]   ref_mem [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".i_ack"},     i_ack,     0);
        chk({tag, ".d_ack"},     d_ack,     0);
        chk({tag, ".i_err"},     i_err,     0);
        chk({tag, ".d_err"},     d_err,     0);
        chk({tag, ".i_rdata"},   i_rdata,   0);
        chk({tag, ".d_rdata"},   d_rdata,   0);
        chk({tag, ".mem_en"},    mem_en,    0);
        chk({tag, ".mem_we"},    mem_we,    0);
        chk({tag, ".mem_addr"},  mem_addr,  0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
        chk({tag, ".busy"},      busy,      0);
    endtask

    function automatic logic [31:0] rand_addr(input logic [31:0] base);
        int k = $urandom_range(0, 9);
        if (k < 5)  return base + 32'(4 * $urandom_range(0, 15));
        if (k == 5) return base + 32'(4 * $urandom_range(WWORDS - 4, WWORDS - 1));
        if (k == 6) return base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        if (k == 7) return base - 32'(4 * $urandom_range(1, 4));
        if (k == 8) return base + WBYTES + 32'(4 * $urandom_range(0, 3));
        return base + 32'(4 * $urandom_range(16, WWORDS - 5));
    endfunction

    task automatic model_grant();
        logic [31:0] a;
        logic [31:0] off;
        int          idx;
        if (act || !(i_req || d_req)) return;
        t_port = (i_req && d_req) ? !m_last : d_req;
        m_last = t_port;
        a      = t_port ? d_addr : i_addr;
        off    = a - (t_port ? DBASE : IBASE);
        t_err  = (a % 4 != 0) || (off >= WBYTES);
        t_we   = t_port && d_we;
        t_wdata = d_wdata;
        if (!t_err) begin
            idx     = (t_port ? WWORDS : 0) + int'(off / 4);
            t_maddr = AW'(idx);
            if (t_we) ref_mem[idx] = d_wdata;
            else      t_data = ref_mem[idx];
        end
        t_start = cyc;
        t_ack   = cyc + (t_err ? 1 : (t_we ? 2 : 2 + LAT));
        act     = 1'b1;
    endtask

    task automatic step();
        bit   e_men;
        bit   e_iack;
        bit   e_dack;
        req_t r;
        @(negedge clk_in);
        cyc++;
        if (act && cyc > t_ack) act = 1'b0;
        e_men  = act && !t_err && (cyc == t_start + 1);
        e_iack = act && (cyc == t_ack) && !t_port;
        e_dack = act && (cyc == t_ack) && t_port;
        if (e_iack) e_irdata = t_err ? 32'h0 : t_data;
        if (e_dack) e_drdata = t_err ? 32'h0 : (t_we ? e_drdata : t_data);

        chk("i_ack",   i_ack,   e_iack);
        chk("d_ack",   d_ack,   e_dack);
        chk("mem_en",  mem_en,  e_men);
        chk("mem_we",  mem_we,  e_men && t_we);
        chk("busy",    busy,    act && (cyc > t_start));
        chk("i_rdata", i_rdata, e_irdata);
        chk("d_rdata", d_rdata, e_drdata);
        if (e_iack) chk("i_err", i_err, t_err);
        if (e_dack) chk("d_err", d_err, t_err);
        if (e_men) begin
            chk("mem_addr", mem_addr, t_maddr);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end

        if (e_iack) i_req = 1'b0;
        if (!i_req) begin
            if (iq.size() > 0) begin
                r = iq.pop_front();
                i_req = 1'b1; i_addr = r.addr;
            end else if (rnd_en && $urandom_range(0, 3) != 0) begin
                i_req = 1'b1; i_addr = rand_addr(IBASE);
            end
        end
        if (e_dack) d_req = 1'b0;
        if (!d_req) begin
            if (dq.size() > 0) begin
                r = dq.pop_front();
                d_req = 1'b1; d_addr = r.addr; d_we = r.we; d_wdata = r.wdata;
            end else if (rnd_en && $urandom_range(0, 3) != 0) begin
                d_req = 1'b1; d_addr = rand_addr(DBASE);
                d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
        end
        model_grant();
    endtask

    task automatic run_idle(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (!act && !i_req && !d_req && iq.size() == 0 && dq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1);
    endtask

    initial begin
        bit reached = 1'b0;
        for (int k = 0; k < (1 << AW); k++) begin
            mem[k]     = $urandom;
            ref_mem[k] = mem[k];
        end
        mem[2]     = 32'h12345678;
        ref_mem[2] = 32'h12345678;

        #1 reset = 1'b1;
        #1 chk_all_zero("reset");
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;

        // idle after reset
        repeat (5) step();

        // fetch of preset word 2
        iq.push_back('{32'h00400008, 1'b0, 32'h0});
        run_idle(20);

        // data write then read-back
        dq.push_back('{32'h10010010, 1'b1, 32'hDEADBEEF});
        dq.push_back('{32'h10010010, 1'b0, 32'h0});
        run_idle(30);

        // both ports requesting back-to-back
        for (int k = 0; k < 4; k++) begin
            iq.push_back('{IBASE + 32'(4 * k), 1'b0, 32'h0});
            dq.push_back('{DBASE + 32'(4 * k), 1'b0, 32'h0});
        end
        run_idle(60);

        // misaligned, below window, above window
        dq.push_back('{32'h10010002, 1'b0, 32'h0});
        dq.push_back('{32'h0FFFFFFC, 1'b0, 32'h0});
        dq.push_back('{32'h10011000, 1'b1, 32'h55AA55AA});
        run_idle(30);

        // reset during the WAIT cycle of a fetch
        iq.push_back('{IBASE + 32'h40, 1'b0, 32'h0});
        for (int k = 0; k < 20 && !reached; k++) begin
            step();
            if (act && !t_port && !t_err && !t_we && cyc == t_start + 2) reached = 1'b1;
        end
        chk("reach_wait", reached, 1);
        #1;
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(posedge clk_in);
        #1 chk_all_zero("rst_hold");
        @(negedge clk_in);
        reset    = 1'b0;
        cyc++;
        act      = 1'b0;
        m_last   = 1'b0;
        e_irdata = '0;
        e_drdata = '0;
        repeat (3) step();
        iq.push_back('{IBASE + 32'h44, 1'b0, 32'h0});
        run_idle(20);

        // randomized traffic
        rnd_en = 1'b1;
        repeat (4000) step();
        rnd_en = 1'b0;
        run_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory (one instruction window and one data window) between the CPU instruction-fetch port and the CPU data port.
Each port uses a req/ack handshake. The block translates byte addresses to word addresses, arbitrates round-robin on ties, sequences a fixed-latency memory access, and flags out-of-range or misaligned accesses.
It sits between the CPU core and the memory inside the top-level dataflow wrapper.

Parameters:
IBASE, 32'h00400000, byte base address of the instruction window
DBASE, 32'h10010000, byte base address of the data window
AW, 11, memory word-address width; each window holds 2^(AW-1) words
LAT, 1, memory read latency in cycles after the mem_en cycle (legal 1..4)

Ports:
clk_in  in  1  system clock, all state updates on its rising edge
reset  in  1  reset, asynchronous, active-high
i_req  in  1  instruction fetch request (reads only)
i_addr  in  32  fetch byte address
i_ack  out  1  one-cycle completion pulse for the fetch port
i_rdata  out  32  fetched word, held until the next i_ack
i_err  out  1  error flag, valid while i_ack=1
d_req  in  1  data request
d_we  in  1  data write enable (1=write, 0=read)
d_addr  in  32  data byte address
d_wdata  in  32  data write word
d_ack  out  1  one-cycle completion pulse for the data port
d_rdata  out  32  read word, held until the next d_ack
d_err  out  1  error flag, valid while d_ack=1
mem_en  out  1  memory enable, exactly one cycle per access
mem_we  out  1  memory write enable (only ever high with mem_en)
mem_addr  out  AW  memory word address
mem_wdata  out  32  memory write word
mem_rdata  in  32  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset:
  - Asynchronous; all outputs go to 0 immediately.
  - State goes to IDLE, rdata registers go to 0, last_grant goes to I.
  - Reset mid-transaction abandons it: no ack is issued, and a write in its ISSUE cycle is not guaranteed to commit.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Samples i_req and d_req. With no request, it stays in IDLE.
  - With one request, it grants that port. With both, it grants the port not in last_grant; the first tie after reset goes to D.
  - On grant it registers the port, address, we and wdata, and updates last_grant.
  - A valid access goes to ISSUE; an erroneous access goes straight to ACK with err=1.
- Address translation:
  - off = addr - BASE, using the base of the granted port, in 32-bit modular arithmetic.
  - Error if addr[1:0] != 0, or off >= 4*2^(AW-1) (this includes addr < BASE via wrap).
  - mem_addr = {0, off[AW:2]} for I and {1, off[AW:2]} for D.
- ISSUE: mem_en=1 for exactly one cycle, with mem_we = granted we, and mem_addr/mem_wdata from the registers. A write goes to ACK; a read goes to WAIT.
- WAIT:
  - A counter runs for LAT cycles.
  - mem_rdata is captured into the granted port's rdata register on the clock edge ending the last WAIT cycle.
  - Then the FSM goes to ACK.
- ACK:
  - The granted port's ack pulses for one cycle. err is 1 only for errored accesses, otherwise 0.
  - On error, rdata is loaded with 0.
  - The FSM then returns to IDLE; there is always one IDLE cycle between transactions.
- Latency (cycle 0 = IDLE cycle sampling req):
  - Read: ack in cycle 2+LAT.
  - Write: ack in cycle 2.
  - Error: ack in cycle 1.
- Requester rules:
  - A requester holds req, addr, we and wdata stable until ack, and may drop req in the ack cycle.
  - A req that stays high after ack is treated as a new request.
  - A req withdrawn early is protocol misuse; the arbiter still completes the transaction and pulses ack.
- mem_we and mem_en are never high outside ISSUE. The non-granted port's outputs are unchanged.

Test Plan:
1. Reset, then release with no requests -> all outputs 0; busy=0; mem_en never asserts.
2. LAT=1. Memory word 2 preset to 0x12345678; i_req with i_addr=0x00400008 at cycle 0 -> mem_en=1, mem_we=0, mem_addr=0x002 in cycle 1. Expected i_ack=1, i_rdata=0x12345678, i_err=0 in cycle 3.
3. Data write followed by read-back:
   - d_we=1, d_addr=0x10010010, d_wdata=0xDEADBEEF -> mem_en=mem_we=1, mem_addr=0x404 in cycle 1; d_ack in cycle 2.
   - Then read the same address -> d_rdata=0xDEADBEEF.
4. i_req and d_req held continuously high -> grants alternate D, I, D, I; each read takes 4 cycles including the IDLE cycle; no port is granted twice in a row.
5. d_addr=0x10010002 (misaligned), then 0x0FFFFFFC (below base), then 0x10011000 (above window, AW=11) -> for each: d_ack one cycle after IDLE, d_err=1, d_rdata=0, no mem_en pulse.
6. Reset asserted during WAIT of a fetch -> all outputs 0 in the same cycle; no i_ack after release; a new fetch completes normally.
